// File: rtl/caravel.sv
// SPI-programmed four-channel compare timer: a 32-bit SPI shift frame sets up CCR/PERIOD registers,
// and a free-running counter drives one registered actuator output per compare channel.
module caravel (
    input  logic       clock,
    input  logic       resetb,
    input  logic       enable_n,
    input  logic       trigger_in_n,
    input  logic       latch_data_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic [3:0] act_out
);

    localparam int unsigned NumCh = 4;

    localparam logic [7:0] CmdRead  = 8'h01;
    localparam logic [7:0] CmdWrite = 8'h02;

    localparam logic [7:0] AddrCtrl      = 8'h00;
    localparam logic [7:0] AddrPeriodLo  = 8'h0A;
    localparam logic [7:0] AddrPeriodHi  = 8'h0B;

    // Bit positions inside the synchronizer bundle.
    localparam int unsigned SyncSs   = 0;
    localparam int unsigned SyncMosi = 1;
    localparam int unsigned SyncSclk = 2;
    localparam int unsigned SyncLat  = 3;
    localparam int unsigned SyncTrig = 4;
    localparam int unsigned SyncEn   = 5;

    logic [5:0] raw_in;
    logic [5:0] sync1_q, sync2_q, prev_q;

    assign raw_in = {enable_n, trigger_in_n, latch_data_n, sclk, mosi, ss_n};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    logic ss_fall, sclk_rise, latch_fall, trig_fall;
    logic ss_low, mosi_s, enable_s;

    assign ss_fall    = prev_q[SyncSs] & ~sync2_q[SyncSs];
    assign sclk_rise  = sync2_q[SyncSclk] & ~prev_q[SyncSclk];
    assign latch_fall = prev_q[SyncLat] & ~sync2_q[SyncLat];
    assign trig_fall  = prev_q[SyncTrig] & ~sync2_q[SyncTrig];
    assign ss_low     = ~sync2_q[SyncSs];
    assign mosi_s     = sync2_q[SyncMosi];
    assign enable_s   = sync2_q[SyncEn];

    // SPI shift engine
    logic [31:0] rx_q, tx_q;
    logic [5:0]  bit_cnt_q;
    logic        shift_en;

    assign shift_en = sclk_rise & ss_low & ~ss_fall & (bit_cnt_q != 6'd32);

    // Frame decode; rx_q is the pre-shift value, so a coincident sclk edge cannot corrupt it.
    logic [7:0]  cmd, addr;
    logic [15:0] data;
    logic        frame_ok, exec_write, exec_read;

    assign cmd        = rx_q[31:24];
    assign addr       = rx_q[23:16];
    assign data       = rx_q[15:0];
    assign frame_ok   = latch_fall & (bit_cnt_q == 6'd32);
    assign exec_write = frame_ok & (cmd == CmdWrite);
    assign exec_read  = frame_ok & (cmd == CmdRead);

    logic [15:0] rd_data;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_q      <= '0;
            tx_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (ss_fall) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end

            if (shift_en) begin
                rx_q <= {rx_q[30:0], mosi_s};
            end

            if (exec_read) begin
                tx_q <= {16'h0000, rd_data};
            end else if (shift_en) begin
                tx_q <= {tx_q[30:0], 1'b0};
            end
        end
    end

    assign miso = tx_q[31];

    // Register file
    logic                    run_q;
    logic [NumCh-1:0][31:0]  ccr_q;
    logic [31:0]             period_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            run_q    <= 1'b0;
            ccr_q    <= '0;
            period_q <= '0;
        end else if (exec_write) begin
            if (addr == AddrCtrl) begin
                run_q <= data[0];
            end
            if (addr == AddrPeriodLo) begin
                period_q[15:0] <= data;
            end
            if (addr == AddrPeriodHi) begin
                period_q[31:16] <= data;
            end
            for (int n = 0; n < NumCh; n++) begin
                if (addr == 8'(2 + 2 * n)) begin
                    ccr_q[n][15:0] <= data;
                end
                if (addr == 8'(3 + 2 * n)) begin
                    ccr_q[n][31:16] <= data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NumCh; n++) begin
            if (addr == 8'(2 + 2 * n)) begin
                rd_data = ccr_q[n][15:0];
            end
            if (addr == 8'(3 + 2 * n)) begin
                rd_data = ccr_q[n][31:16];
            end
        end
        if (addr == AddrCtrl) begin
            rd_data = {15'h0000, run_q};
        end
        if (addr == AddrPeriodLo) begin
            rd_data = period_q[15:0];
        end
        if (addr == AddrPeriodHi) begin
            rd_data = period_q[31:16];
        end
    end

    // Compare timer
    logic [31:0]      count_q, count_d;
    logic [NumCh-1:0] act_d;
    logic             timer_en;

    assign timer_en = ~enable_s & run_q;

    always_comb begin
        count_d = count_q;
        if (enable_s || trig_fall) begin
            count_d = '0;
        end else if (run_q) begin
            if (period_q == 32'd0 || count_q == period_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_comb begin
        act_d = '0;
        for (int n = 0; n < NumCh; n++) begin
            act_d[n] = timer_en & (count_q < ccr_q[n]);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            count_q <= '0;
            act_out <= '0;
        end else begin
            count_q <= count_d;
            act_out <= act_d;
        end
    end

endmodule

// File: tb/tb_caravel.sv
// Scoreboard bench for caravel: stimulus pushes expected values, a monitor process compares
// them against observations of SPI read-back words and actuator behaviour.
module tb_caravel;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable_n, trigger_in_n, latch_data_n, sclk, mosi, ss_n;
    logic       miso;
    logic [3:0] act_out;

    caravel dut (
        .clock       (clock),
        .resetb      (resetb),
        .enable_n    (enable_n),
        .trigger_in_n(trigger_in_n),
        .latch_data_n(latch_data_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .ss_n        (ss_n),
        .miso        (miso),
        .act_out     (act_out)
    );

    always #5 clock = ~clock;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        obs_valid = 1'b0;
    logic [31:0] obs_data  = '0;
    logic        done      = 1'b0;
    int          total     = 0;
    int          bad       = 0;

    // Monitor: pops one expectation per observation.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clock);
            if (obs_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_observation: got=%h want=<none>", obs_data);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (obs_data !== e) begin
                        bad++;
                        $display("FAIL %s: got=%h want=%h", nm, obs_data, e);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() != 0) begin
                    total++;
                    bad++;
                    $display("FAIL leftover_expectations: got=%0d want=0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic observe(input logic [31:0] v);
        obs_data  = v;
        obs_valid = 1'b1;
        @(negedge clock);
        #1;
        obs_valid = 1'b0;
    endtask

    // sclk runs at clock/8: four clocks low, four high; master samples miso on the rising edge.
    task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = word[31-i];
            tick(4);
            sclk = 1'b1;
            got  = {got[30:0], miso};
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [31:0] got);
        ss_n = 1'b0;
        tick(4);
        spi_bits(word, nbits, got);
        tick(4);
        ss_n = 1'b1;
        mosi = 1'b0;
        tick(4);
    endtask

    task automatic latch();
        latch_data_n = 1'b0;
        tick(4);
        latch_data_n = 1'b1;
        tick(4);
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [15:0] data);
        logic [31:0] dummy;
        spi_frame({8'h02, addr, data}, 32, dummy);
        latch();
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [31:0] got);
        logic [31:0] dummy;
        spi_frame({8'h01, addr, 16'h0000}, 32, dummy);
        latch();
        spi_frame(32'h0, 32, got);
    endtask

    task automatic check_read(input string name, input logic [7:0] addr, input logic [15:0] v);
        logic [31:0] got;
        expect_val(name, {16'h0000, v});
        read_reg(addr, got);
        observe(got);
    endtask

    logic [7:0]  rd_addr[8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic [15:0] rd_exp[8]  = '{16'h0008, 16'h0, 16'h000F, 16'h0, 16'h0080, 16'h0, 16'h00F0, 16'h0};
    int          hit_exp[4] = '{8, 15, 128, 240};

    initial begin
        logic [31:0] got;
        int          hits[4];
        int          hi, first;

        resetb       = 1'b0;
        enable_n     = 1'b1;
        trigger_in_n = 1'b1;
        latch_data_n = 1'b1;
        sclk         = 1'b0;
        mosi         = 1'b0;
        ss_n         = 1'b1;
        tick(3);
        expect_val("reset_miso", 32'h0);
        observe({31'h0, miso});
        expect_val("reset_act_out", 32'h0);
        observe({28'h0, act_out});
        resetb = 1'b1;
        tick(4);
        check_read("reset_ctrl", 8'h00, 16'h0000);

        // Basic write / read-back of the full 32-bit response word.
        write_reg(8'h02, 16'h0008);
        check_read("ccr0_word", 8'h02, 16'h0008);

        write_reg(8'h04, 16'h000F);
        write_reg(8'h06, 16'h0080);
        write_reg(8'h08, 16'h00F0);
        for (int i = 0; i < 8; i++) begin
            check_read($sformatf("ccr_rb_%02h", rd_addr[i]), rd_addr[i], rd_exp[i]);
        end

        // Short frame must not execute; unmapped address reads zero.
        spi_frame({8'h02, 8'h02, 16'h5555}, 31, got);
        latch();
        check_read("short_frame", 8'h02, 16'h0008);
        write_reg(8'h1F, 16'hABCD);
        check_read("unmapped_1f", 8'h1F, 16'h0000);

        // Timer: PERIOD 0xFF gives a 256-clock cycle.
        write_reg(8'h0A, 16'h00FF);
        write_reg(8'h00, 16'hFFFF);
        check_read("ctrl_run_only", 8'h00, 16'h0001);
        enable_n = 1'b0;
        tick(20);
        hits = '{0, 0, 0, 0};
        for (int c = 0; c < 256; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (act_out[n]) hits[n]++;
            end
            tick(1);
        end
        for (int n = 0; n < 4; n++) begin
            expect_val($sformatf("duty_ch%0d", n), hit_exp[n]);
            observe(hits[n]);
        end

        enable_n = 1'b1;
        tick(5);
        expect_val("disabled_act_out", 32'h0);
        observe({28'h0, act_out});
        tick(10);
        enable_n = 1'b0;
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (act_out[0]) hi++;
            tick(1);
        end
        expect_val("restart_from_zero", 32'd8);
        observe(hi);

        // Trigger mid-period.
        tick(50);
        expect_val("pre_trigger_act0", 32'h0);
        observe({31'h0, act_out[0]});
        trigger_in_n = 1'b0;
        hi    = 0;
        first = -1;
        for (int c = 0; c < 40; c++) begin
            if (act_out[0]) begin
                if (first < 0) first = c;
                hi++;
            end
            tick(1);
            if (c == 3) trigger_in_n = 1'b1;
        end
        expect_val("trigger_latency_le4", 32'h1);
        observe({31'h0, (first >= 0 && first <= 4)});
        expect_val("trigger_high_clocks", 32'd8);
        observe(hi);

        // Reset mid-frame with miso high and the timer running.
        spi_frame({8'h01, 8'h08, 16'h0000}, 32, got);
        latch();
        ss_n = 1'b0;
        tick(4);
        spi_bits(32'h0, 24, got);
        tick(2);
        expect_val("miso_before_reset", 32'h1);
        observe({31'h0, miso});
        resetb = 1'b0;
        tick(1);
        expect_val("reset_mid_miso", 32'h0);
        observe({31'h0, miso});
        expect_val("reset_mid_act", 32'h0);
        observe({28'h0, act_out});
        resetb = 1'b1;
        tick(2);
        ss_n = 1'b1;
        mosi = 1'b0;
        tick(4);
        check_read("post_reset_ctrl", 8'h00, 16'h0000);
        check_read("post_reset_ccr0", 8'h02, 16'h0000);
        check_read("post_reset_ccr3", 8'h08, 16'h0000);
        check_read("post_reset_period", 8'h0A, 16'h0000);
        expect_val("post_reset_act", 32'h0);
        observe({28'h0, act_out});

        tick(2);
        done = 1'b1;
    end

endmodule

// File: doc/caravel.md
CARAVEL -- requirements
Module: caravel

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock first, then reset.
REQ-002 clock  input  1  system clock, 40 MHz nominal; all state is clocked on its rising edge.
REQ-003 resetb  input  1  asynchronous active-low reset.
REQ-004 enable_n  input  1  active-low enable for the compare timer.
REQ-005 trigger_in_n  input  1  active-low trigger; a falling edge restarts the counter.
REQ-006 latch_data_n  input  1  active-low latch; a falling edge executes the captured SPI frame.
REQ-007 sclk  input  1  SPI clock, idle low, at most clock/8; mosi is sampled on its rising edge.
REQ-008 mosi  input  1  SPI serial data in, MSB first.
REQ-009 ss_n  input  1  SPI slave select, active low.
REQ-010 miso  output  1  SPI serial data out, MSB first.
REQ-011 act_out  output  4  actuator drive outputs, one per compare channel.

Function
REQ-012 sclk, mosi, ss_n, latch_data_n, trigger_in_n and enable_n SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals.
REQ-013 ss_n falling edge SHALL clear the 6-bit bit counter.
REQ-014 Each sclk rising edge with ss_n low SHALL perform three actions:
- shift mosi into the 32-bit rx register (LSB in);
- shift the 32-bit tx register left by one;
- increment the bit counter, saturating at 32.
Bits beyond 32 SHALL be ignored.
REQ-015 miso SHALL continuously equal tx[31].
REQ-016 Frame format SHALL be {cmd[7:0], addr[7:0], data[15:0]}.
REQ-017 On a latch_data_n falling edge, the frame SHALL execute only when the bit counter equals 32.
- cmd 0x02 (write): reg[addr] <= data.
- cmd 0x01 (read): tx <= {16'h0000, reg[addr]}.
- Any other cmd: no effect.
REQ-018 Register map (16-bit registers):
- 0x00 CTRL: bit0 = run; other bits read 0.
- 0x02/0x03 CCR0 lo/hi; 0x04/0x05 CCR1; 0x06/0x07 CCR2; 0x08/0x09 CCR3.
- 0x0A/0x0B PERIOD lo/hi.
- Unmapped addresses SHALL read 0; writes to them SHALL be ignored.
REQ-019 The 32-bit counter SHALL increment each clock while enable_n is low and CTRL.run is 1.
- It SHALL wrap to 0 when it equals PERIOD.
- PERIOD = 0 SHALL hold the counter at 0.
REQ-020 enable_n high SHALL hold the counter at 0 and force act_out to 0.
REQ-021 act_out[n] SHALL be registered, high when the counter < CCRn and the timer is enabled.
REQ-022 A trigger_in_n falling edge SHALL zero the counter on the next clock and takes priority over increment and wrap.
REQ-023 Register writes SHALL take effect one clock after the latch edge; CCR/PERIOD are compared directly, with no shadowing.
REQ-024 If a latch edge and an sclk edge coincide, the latch SHALL use the rx value from before the shift.

Reset
REQ-025 resetb low SHALL clear, asynchronously:
- all registers, rx, tx, bit counter, counter and synchronizers;
- miso = 0, act_out = 4'b0000.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the next ss_n falling edge starts a new frame.

Verification
REQ-027 Write 0x02 addr 0x02 data 0x0008, latch, then read addr 0x02 (read frame, latch, 32 zero bits) -> received low 16 bits = 0x0008, upper 16 = 0.
REQ-028 Write CCR0..CCR3 = 0x8, 0xF, 0x80, 0xF0 (hi halves 0); read back 0x02..0x09 -> 0x0008, 0, 0x000F, 0, 0x0080, 0, 0x00F0, 0.
REQ-029 Frame of only 31 bits, then latch -> target register unchanged; read of unmapped addr 0x1F after a write to it -> 0x0000.
REQ-030 PERIOD = 0xFF, CCR0 = 0x08, run = 1, enable_n = 0 -> act_out[0] high 8 of every 256 clocks; raising enable_n -> act_out = 0 and counter = 0.
REQ-031 Pulse trigger_in_n low mid-period -> counter restarts at 0 and act_out[0] goes high within 4 clocks.
REQ-032 Assert resetb mid-frame -> miso = 0, act_out = 0, all registers read 0 afterwards.
